// File: rtl/line_buff_fill_if.sv
`default_nettype none
// ============================================================================
// Module     : line_buff_fill_if
// Description: Bundles every signal of the line buffer fill responder except
//              clock and reset: the fill request/done handshake with the line
//              buffer controller, the frame memory read port and the two line
//              buffer write ports.
//   buff_fill_req_i  [1:0]  one-hot fill request (01 = A, 10 = B)
//   frame_sync_i            restart tile row index at row 0
//   mem_rd_en_o             frame memory read strobe
//   mem_addr_o              frame memory read address
//   mem_data_i              frame memory read data
//   buff_wr_en_o     [1:0]  one-hot line buffer write enable
//   buff_wr_addr_o          line buffer write address (tile index)
//   buff_wr_data_o          line buffer write data
//   buff_fill_done_o [1:0]  one-cycle fill-complete pulse
//   busy_o                  fill in progress
//   Modports: slave  = the responder (line_buff_fill)
//             master = its environment (controller + frame memory)
// Revision   : 1.0 - initial release
// ============================================================================
interface line_buff_fill_if #(
  parameter int MEM_ADDR_WIDTH = 15,
  parameter int TILE_CTR_WIDTH = 8,
  parameter int PXL_WIDTH      = 12
);
  logic [1:0]                buff_fill_req_i;
  logic                      frame_sync_i;
  logic                      mem_rd_en_o;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
  logic [PXL_WIDTH-1:0]      mem_data_i;
  logic [1:0]                buff_wr_en_o;
  logic [TILE_CTR_WIDTH-1:0] buff_wr_addr_o;
  logic [PXL_WIDTH-1:0]      buff_wr_data_o;
  logic [1:0]                buff_fill_done_o;
  logic                      busy_o;

  modport slave (
    input  buff_fill_req_i, frame_sync_i, mem_data_i,
    output mem_rd_en_o, mem_addr_o, buff_wr_en_o, buff_wr_addr_o,
           buff_wr_data_o, buff_fill_done_o, busy_o
  );

  modport master (
    output buff_fill_req_i, frame_sync_i, mem_data_i,
    input  mem_rd_en_o, mem_addr_o, buff_wr_en_o, buff_wr_addr_o,
           buff_wr_data_o, buff_fill_done_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/line_buff_fill.sv
`default_nettype none
// ============================================================================
// Module     : line_buff_fill
// Description: Responder of the line buffer fill handshake. On a one-hot fill
//              request it reads one row of TILE_PER_LINE tiles from frame
//              memory (fixed read latency), writes them into the requested
//              line buffer and pulses the matching fill-done bit. Tracks the
//              current tile row and its base address, wrapping after the last
//              row, and restarts at row 0 on frame_sync_i.
//   clk_i   : clock
//   rstn_i  : asynchronous active-low reset
//   bus     : line_buff_fill_if.slave (request/done handshake, frame memory
//             read port, line buffer write ports, busy)
// Revision   : 1.0 - initial release
// ============================================================================
module line_buff_fill #(
  parameter int WIDTH_PX       = 640,
  parameter int HEIGHT_LNS     = 480,
  parameter int TILE_WIDTH     = 4,
  parameter int TILE_PER_LINE  = WIDTH_PX / TILE_WIDTH,
  parameter int TILE_PER_COL   = HEIGHT_LNS / TILE_WIDTH,
  parameter int TILE_CTR_WIDTH = $clog2(TILE_PER_LINE),
  parameter int MEM_ADDR_WIDTH = $clog2(TILE_PER_LINE * TILE_PER_COL),
  parameter int PXL_WIDTH      = 12,
  parameter int MEM_RD_LATENCY = 2   // must be >= 1
) (
  input  wire logic        clk_i,
  input  wire logic        rstn_i,
  line_buff_fill_if.slave  bus
);

  localparam int ROW_WIDTH = $clog2(TILE_PER_COL);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [TILE_CTR_WIDTH-1:0] LAST_TILE = TILE_CTR_WIDTH'(TILE_PER_LINE - 1);
  localparam logic [ROW_WIDTH-1:0]      LAST_ROW  = ROW_WIDTH'(TILE_PER_COL - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] ROW_STEP  = MEM_ADDR_WIDTH'(TILE_PER_LINE);

  logic [1:0]                state;
  logic [1:0]                target;
  logic [TILE_CTR_WIDTH-1:0] tile_idx;
  logic [ROW_WIDTH-1:0]      row_idx;
  logic [MEM_ADDR_WIDTH-1:0] row_base;
  logic                      sync_pending;

  // Registered read strobe/address plus the tile index that accompanies it
  // down the latency pipeline.
  logic                      rd_en;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr;
  logic [TILE_CTR_WIDTH-1:0] rd_tile;

  logic                      vld_sr  [MEM_RD_LATENCY];
  logic [TILE_CTR_WIDTH-1:0] tile_sr [MEM_RD_LATENCY];

  logic req_ok;
  logic wr_vld;
  logic last_wr;

  // Only a clean one-hot request is accepted; 11 and 00 never start a fill.
  assign req_ok  = (bus.buff_fill_req_i == 2'b01) || (bus.buff_fill_req_i == 2'b10);
  assign wr_vld  = vld_sr[MEM_RD_LATENCY-1];
  assign last_wr = wr_vld && (tile_sr[MEM_RD_LATENCY-1] == LAST_TILE);

  // --------------------------------------------------------------------------
  // Control FSM, read issue and row tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      target       <= 2'b00;
      tile_idx     <= '0;
      row_idx      <= '0;
      row_base     <= '0;
      sync_pending <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      rd_tile      <= '0;
    end else begin
      rd_en <= 1'b0;
      case (state)
        IDLE: begin
          // Clearing the row here and starting the fill on the same edge
          // makes a simultaneous sync + request read row 0.
          if (bus.frame_sync_i) begin
            row_idx  <= '0;
            row_base <= '0;
          end
          if (req_ok) begin
            state    <= READ;
            target   <= bus.buff_fill_req_i;
            tile_idx <= '0;
          end
        end

        READ: begin
          rd_en   <= 1'b1;
          rd_addr <= row_base + MEM_ADDR_WIDTH'(tile_idx);
          rd_tile <= tile_idx;
          if (tile_idx == LAST_TILE) begin
            state <= DRAIN;
          end else begin
            tile_idx <= tile_idx + TILE_CTR_WIDTH'(1);
          end
          if (bus.frame_sync_i) begin
            sync_pending <= 1'b1;
          end
        end

        DRAIN: begin
          if (last_wr) begin
            state <= DONE;
          end
          if (bus.frame_sync_i) begin
            sync_pending <= 1'b1;
          end
        end

        DONE: begin
          state        <= IDLE;
          sync_pending <= 1'b0;
          // A sync seen during the fill (or right now) replaces the advance.
          if (sync_pending || bus.frame_sync_i || (row_idx == LAST_ROW)) begin
            row_idx  <= '0;
            row_base <= '0;
          end else begin
            row_idx  <= row_idx + ROW_WIDTH'(1);
            row_base <= row_base + ROW_STEP;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read-valid / tile-index pipeline: stage MEM_RD_LATENCY-1 lines up with
  // the data the frame memory returns for that read.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < MEM_RD_LATENCY; k++) begin : g_rd_pipe
      if (k == 0) begin : g_head
        always_ff @(posedge clk_i or negedge rstn_i) begin
          if (!rstn_i) begin
            vld_sr[0]  <= 1'b0;
            tile_sr[0] <= '0;
          end else begin
            vld_sr[0]  <= rd_en;
            tile_sr[0] <= rd_tile;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk_i or negedge rstn_i) begin
          if (!rstn_i) begin
            vld_sr[k]  <= 1'b0;
            tile_sr[k] <= '0;
          end else begin
            vld_sr[k]  <= vld_sr[k-1];
            tile_sr[k] <= tile_sr[k-1];
          end
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.mem_rd_en_o      = rd_en;
  assign bus.mem_addr_o       = rd_addr;
  assign bus.buff_wr_en_o     = wr_vld ? target : 2'b00;
  assign bus.buff_wr_addr_o   = tile_sr[MEM_RD_LATENCY-1];
  // Gated so the write port reads zero whenever no write is in flight.
  assign bus.buff_wr_data_o   = wr_vld ? bus.mem_data_i : '0;
  assign bus.buff_fill_done_o = (state == DONE) ? target : 2'b00;
  assign bus.busy_o           = (state == READ) || (state == DRAIN);

endmodule
`default_nettype wire
